// File: rtl/ctrl_decode_if.sv
// Handshake bundle between fetch, the LEGv8 decode stage and execute.
// The stage connects through the slave modport; the environment uses master.
interface ctrl_decode_if #(
  parameter int INSN_W  = 32,
  parameter int ALUOP_W = 2
);
  logic               in_valid;
  logic [INSN_W-1:0]  in_instr;
  logic               in_ready;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [INSN_W-1:0]  out_instr;
  logic               out_uncond_branch;
  logic               out_flag_branch;
  logic               out_zero_branch;
  logic               out_mem_read;
  logic               out_mem_to_reg;
  logic               out_mem_write;
  logic               out_flag_write;
  logic               out_alu_src;
  logic [ALUOP_W-1:0] out_alu_op;
  logic               out_reg_write;
  logic               out_illegal;
  logic               busy;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_uncond_branch, out_flag_branch,
           out_zero_branch, out_mem_read, out_mem_to_reg, out_mem_write,
           out_flag_write, out_alu_src, out_alu_op, out_reg_write, out_illegal, busy
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_uncond_branch, out_flag_branch,
           out_zero_branch, out_mem_read, out_mem_to_reg, out_mem_write,
           out_flag_write, out_alu_src, out_alu_op, out_reg_write, out_illegal, busy
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// LEGv8 decode/control stage with a registered ID/EX bundle, load-use bubble,
// multi-cycle MUL hold and a sticky undefined-opcode trap cleared by flush.
module ctrl_decode_stage #(
  parameter int INSN_W     = 32,
  parameter int ALUOP_W    = 2,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_decode_if.slave bus
);
  localparam int CNT_W  = $clog2(MUL_CYCLES + 1);
  localparam bit MUL_MC = (MUL_CYCLES > 1);

  typedef enum logic [1:0] {RUN = 2'd0, MUL_WAIT = 2'd1, TRAP = 2'd2} state_e;

  typedef struct packed {
    logic               uncond_branch;
    logic               flag_branch;
    logic               zero_branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               flag_write;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
  } ctrl_t;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   mul_cnt;
  logic               vld_q;
  logic [INSN_W-1:0]  instr_q;
  ctrl_t              ctrl_q;
  ctrl_t              dec;
  logic               illegal_q;
  logic               in_ready;
  logic               accept;
  logic               hazard;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic is_r, is_flags, is_mul, is_ldur, is_stur, is_imm, is_mov;
  logic is_cbz, is_bcond, is_b, is_undef;

  assign op11 = bus.in_instr[INSN_W-1 -: 11];
  assign op10 = bus.in_instr[INSN_W-1 -: 10];
  assign op9  = bus.in_instr[INSN_W-1 -: 9];
  assign op8  = bus.in_instr[INSN_W-1 -: 8];
  assign op6  = bus.in_instr[INSN_W-1 -: 6];

  // Longest opcode wins: shorter formats are only tried when no 11-bit match.
  always_comb begin
    is_r     = 1'b0;
    is_flags = 1'b0;
    is_mul   = 1'b0;
    is_ldur  = 1'b0;
    is_stur  = 1'b0;
    is_imm   = 1'b0;
    is_mov   = 1'b0;
    is_cbz   = 1'b0;
    is_bcond = 1'b0;
    is_b     = 1'b0;
    is_undef = 1'b0;
    case (op11)
      11'h458, 11'h658, 11'h450, 11'h550: is_r = 1'b1;
      11'h558, 11'h758: begin is_r = 1'b1; is_flags = 1'b1; end
      11'h4D8:          begin is_r = 1'b1; is_mul   = 1'b1; end
      11'h7C2:          is_ldur = 1'b1;
      11'h7C0:          is_stur = 1'b1;
      default: begin
        if (op10 == 10'h244 || op10 == 10'h344)  is_imm   = 1'b1;
        else if (op9 == 9'h1A5 || op9 == 9'h1E5) is_mov   = 1'b1;
        else if (op8 == 8'hB4 || op8 == 8'hB5)   is_cbz   = 1'b1;
        else if (op8 == 8'h54)                   is_bcond = 1'b1;
        else if (op6 == 6'h05)                   is_b     = 1'b1;
        else                                     is_undef = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec               = '0;
    dec.uncond_branch = is_b;
    dec.flag_branch   = is_bcond;
    dec.zero_branch   = is_cbz;
    dec.mem_read      = is_ldur;
    dec.mem_to_reg    = is_ldur;
    dec.mem_write     = is_stur;
    dec.flag_write    = is_flags;
    dec.alu_src       = is_ldur | is_stur | is_imm | is_mov;
    dec.reg_write     = is_r | is_ldur | is_imm | is_mov;
    if (is_r)                   dec.alu_op = ALUOP_W'(2'b10);
    else if (is_imm || is_mov)  dec.alu_op = ALUOP_W'(2'b11);
    else if (is_cbz || is_bcond) dec.alu_op = ALUOP_W'(2'b01);
    else                        dec.alu_op = ALUOP_W'(2'b00);
  end

  // Load-use check against the register the held LDUR is about to write.
  logic       uses_rn, uses_rm, uses_rt;
  logic [4:0] ld_rd;
  assign uses_rn = !(is_b || is_bcond || is_mov);
  assign uses_rm = is_r;
  assign uses_rt = is_stur || is_cbz;
  assign ld_rd   = instr_q[4:0];
  assign hazard  = vld_q && ctrl_q.mem_read && (ld_rd != 5'd31) &&
                   ((uses_rn && bus.in_instr[9:5]   == ld_rd) ||
                    (uses_rm && bus.in_instr[20:16] == ld_rd) ||
                    (uses_rt && bus.in_instr[4:0]   == ld_rd));

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (accept && is_undef)             state_nxt = TRAP;
          else if (accept && is_mul && MUL_MC) state_nxt = MUL_WAIT;
        end
        MUL_WAIT: if (mul_cnt == CNT_W'(1))   state_nxt = RUN;
        TRAP:     state_nxt = TRAP;
        default:  state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == RUN) && !bus.flush && !hazard && (!vld_q || bus.out_ready);
    bus.busy = (state != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      instr_q   <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      mul_cnt   <= '0;
    end else if (bus.flush) begin
      vld_q     <= 1'b0;
      illegal_q <= 1'b0;
      mul_cnt   <= '0;
    end else if (accept) begin
      instr_q   <= bus.in_instr;
      ctrl_q    <= dec;
      illegal_q <= is_undef;
      vld_q     <= !is_undef && !(is_mul && MUL_MC);
      mul_cnt   <= (is_mul && MUL_MC) ? CNT_W'(MUL_CYCLES - 1) : '0;
    end else if (state == MUL_WAIT) begin
      // MUL sits in the register with valid low until its latency elapses.
      mul_cnt <= mul_cnt - CNT_W'(1);
      if (mul_cnt == CNT_W'(1)) vld_q <= 1'b1;
    end else if (vld_q && bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = vld_q;
  assign bus.out_instr         = instr_q;
  assign bus.out_uncond_branch = ctrl_q.uncond_branch;
  assign bus.out_flag_branch   = ctrl_q.flag_branch;
  assign bus.out_zero_branch   = ctrl_q.zero_branch;
  assign bus.out_mem_read      = ctrl_q.mem_read;
  assign bus.out_mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.out_mem_write     = ctrl_q.mem_write;
  assign bus.out_flag_write    = ctrl_q.flag_write;
  assign bus.out_alu_src       = ctrl_q.alu_src;
  assign bus.out_alu_op        = ctrl_q.alu_op;
  assign bus.out_reg_write     = ctrl_q.reg_write;
  assign bus.out_illegal       = illegal_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: a latency/occupancy model predicts
// handshake outputs each cycle and queues the expected decoded bundles.
module tb_ctrl_decode_stage;
  localparam int INSN_W     = 32;
  localparam int ALUOP_W    = 2;
  localparam int MUL_CYCLES = 4;

  localparam int K_R = 0, K_RF = 1, K_MUL = 2, K_LDUR = 3, K_STUR = 4, K_IMM = 5;
  localparam int K_MOV = 6, K_CB = 7, K_BCOND = 8, K_B = 9, K_BAD = 10;

  typedef struct packed { logic [3:0] w; logic [10:0] pat; logic [3:0] k; } op_t;
  typedef struct packed { logic [31:0] instr; logic [10:0] ctrl; } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_decode_if #(.INSN_W(INSN_W), .ALUOP_W(ALUOP_W)) bus ();

  ctrl_decode_stage #(.INSN_W(INSN_W), .ALUOP_W(ALUOP_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  op_t     optab[$];
  bundle_t exp_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  // Model: one held instruction, cycles until it becomes visible, trap flag.
  bit      m_full, m_trap;
  int      m_wait, m_kind;
  bundle_t m_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_op(input int w, input int pat, input int k);
    op_t e;
    e.w = 4'(w); e.pat = 11'(pat); e.k = 4'(k);
    optab.push_back(e);
  endtask

  function automatic int classify(logic [31:0] i);
    for (int w = 11; w >= 6; w--)
      foreach (optab[e])
        if (int'(optab[e].w) == w && (i[31:21] >> (11 - w)) == optab[e].pat) return int'(optab[e].k);
    return K_BAD;
  endfunction

  // {uncond, flag_br, zero_br, mem_rd, mem2reg, mem_wr, flag_wr, alu_src, alu_op, reg_write}
  function automatic logic [10:0] ctrl_of(int k);
    case (k)
      K_R, K_MUL:   return {8'b0000_0000, 2'b10, 1'b1};
      K_RF:         return {8'b0000_0010, 2'b10, 1'b1};
      K_LDUR:       return {8'b0001_1001, 2'b00, 1'b1};
      K_STUR:       return {8'b0000_0101, 2'b00, 1'b0};
      K_IMM, K_MOV: return {8'b0000_0001, 2'b11, 1'b1};
      K_CB:         return {8'b0010_0000, 2'b01, 1'b0};
      K_BCOND:      return {8'b0100_0000, 2'b01, 1'b0};
      K_B:          return {8'b1000_0000, 2'b00, 1'b0};
      default:      return 11'b0;
    endcase
  endfunction

  function automatic bit reads_reg(logic [31:0] i, logic [4:0] r);
    int k;
    bit hit;
    k = classify(i);
    hit = 1'b0;
    if (k != K_B && k != K_BCOND && k != K_MOV && i[9:5] == r) hit = 1'b1;
    if ((k == K_R || k == K_RF || k == K_MUL) && i[20:16] == r) hit = 1'b1;
    if ((k == K_STUR || k == K_CB) && i[4:0] == r) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] gen_legal();
    op_t e;
    logic [31:0] ins;
    int sh;
    e = optab[$urandom_range(0, optab.size() - 1)];
    ins = $urandom;
    ins[20:16] = pick_reg();
    ins[9:5]   = pick_reg();
    ins[4:0]   = pick_reg();
    sh = 32 - int'(e.w);
    ins = (ins & ~(32'hFFFF_FFFF << sh)) | (32'(e.pat) << sh);
    return ins;
  endfunction

  function automatic bundle_t dut_bundle();
    return {bus.out_instr, bus.out_uncond_branch, bus.out_flag_branch, bus.out_zero_branch,
            bus.out_mem_read, bus.out_mem_to_reg, bus.out_mem_write, bus.out_flag_write,
            bus.out_alu_src, bus.out_alu_op, bus.out_reg_write};
  endfunction

  // One cycle: drive after posedge, check at negedge, advance model for the edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl,
                      output bit acc);
    bit exp_ov, exp_rdy, hz, oe;
    int k;
    oe = ordy && !fl;
    bus.in_valid = v; bus.in_instr = ins; bus.out_ready = oe; bus.flush = fl;
    @(negedge clk);
    exp_ov  = m_full && (m_wait == 0);
    hz      = exp_ov && (m_kind == K_LDUR) && (m_b.instr[4:0] != 5'd31) &&
              reads_reg(ins, m_b.instr[4:0]);
    exp_rdy = !m_trap && (m_wait == 0) && !fl && !hz && (!exp_ov || oe);
    check("in_ready",    64'(bus.in_ready),    64'(exp_rdy));
    check("out_valid",   64'(bus.out_valid),   64'(exp_ov));
    check("out_illegal", 64'(bus.out_illegal), 64'(m_trap));
    check("busy",        64'(bus.busy),        64'(m_trap || m_wait > 0));
    acc = v && exp_rdy;
    if (fl) begin
      m_full = 1'b0; m_wait = 0; m_trap = 1'b0;
      exp_q.delete();
    end else if (acc) begin
      k = classify(ins);
      if (k == K_BAD) begin
        m_trap = 1'b1; m_full = 1'b0; m_wait = 0;
      end else begin
        m_full = 1'b1; m_kind = k;
        m_b    = {ins, ctrl_of(k)};
        m_wait = (k == K_MUL) ? MUL_CYCLES - 1 : 0;
        exp_q.push_back(m_b);
      end
    end else if (exp_ov && oe) begin
      m_full = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] ins, input bit ordy);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(1'b1, ins, ordy, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: instr %h not accepted within 20 cycles", ins);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #2;
    check("rst_out_valid", 64'(bus.out_valid),   64'(0));
    check("rst_bundle",    64'(dut_bundle()),    64'(0));
    check("rst_busy",      64'(bus.busy),        64'(0));
    check("rst_illegal",   64'(bus.out_illegal), 64'(0));
    m_full = 1'b0; m_wait = 0; m_trap = 1'b0; m_kind = K_BAD; m_b = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall hold.
  initial begin
    bit      prev_stall, prev_flush;
    bundle_t prev_b, e;
    prev_stall = 1'b0; prev_flush = 1'b0; prev_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !prev_flush)
          check("stall_hold", 64'({bus.out_valid, dut_bundle()}), 64'({1'b1, prev_b}));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_output: got %h expected nothing", dut_bundle());
          end else begin
            e = exp_q.pop_front();
            check("out_bundle", 64'(dut_bundle()), 64'(e));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_flush = bus.flush;
        prev_b     = dut_bundle();
      end
    end
  end

  initial begin
    bit acc;
    add_op(11, 'h458, K_R);   add_op(11, 'h658, K_R);   add_op(11, 'h450, K_R);
    add_op(11, 'h550, K_R);   add_op(11, 'h558, K_RF);  add_op(11, 'h758, K_RF);
    add_op(11, 'h4D8, K_MUL); add_op(11, 'h7C2, K_LDUR); add_op(11, 'h7C0, K_STUR);
    add_op(10, 'h244, K_IMM); add_op(10, 'h344, K_IMM);
    add_op(9,  'h1A5, K_MOV); add_op(9,  'h1E5, K_MOV);
    add_op(8,  'hB4, K_CB);   add_op(8,  'hB5, K_CB);   add_op(8, 'h54, K_BCOND);
    add_op(6,  'h05, K_B);

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    send(32'h8B02_0023, 1'b1);           // ADD X3,X1,X2
    idle(2);
    send(32'hF840_0041, 1'b1);           // LDUR X1,[X2,#0]
    send(32'h8B04_0023, 1'b1);           // ADD X3,X1,X4 (dependent)
    idle(2);
    send(32'hF840_005F, 1'b1);           // LDUR X31
    send(32'h8B04_03E3, 1'b1);           // ADD X3,X31,X4
    idle(2);
    send(32'h9B02_0025, 1'b1);           // MUL X5,X1,X2
    send(32'h8B02_0023, 1'b1);
    idle(2);
    send(32'hEB02_0026, 1'b0);           // SUBS X6,X1,X2 held by out_ready=0
    repeat (5) step(1'b1, 32'h8B02_0023, 1'b0, 1'b0, acc);
    send(32'h8B02_0023, 1'b1);
    idle(2);
    send(32'hFFFF_FFFF, 1'b1);           // undefined -> trap
    repeat (3) step(1'b1, 32'h8B02_0023, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);  // flush clears trap
    send(32'h8B02_0023, 1'b1);
    idle(2);
    send(32'h9B02_0025, 1'b1);           // MUL, flushed while waiting
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h8B02_0023, 1'b1, 1'b1, acc);
    idle(6);
    send(32'h9B02_0025, 1'b1);           // MUL, reset mid-wait
    idle(2);
    do_reset();
    idle(6);

    repeat (600) begin
      int          r;
      logic [31:0] ins;
      r   = $urandom_range(0, 99);
      ins = (r < 3) ? 32'hFFFF_FFFF : gen_legal();
      step($urandom_range(0, 99) < 70, ins, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 4, acc);
    end
    idle(10);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
